// File: rtl/volts_scale_pkg.sv
// Shared types and reset constants for the volts/div scaling pipeline.
package volts_scale_pkg;

   // Post-gain processing applied in the second stage
   typedef enum logic [1:0] {
      PASS     = 2'd0,
      CLAMP    = 2'd1,
      DEADBAND = 2'd2,
      RSVD     = 2'd3
   } mode_t;

   // Configuration restored by reset: pass-through at unity gain
   localparam mode_t       RST_MODE   = PASS;
   localparam int unsigned RST_THRESH = 0;
   localparam int unsigned RST_SHIFT  = 0;

endpackage

// File: rtl/volts_sat_shl.sv
// Combinational saturating left shift: result = data << shift, or all-ones on overflow.
module volts_sat_shl #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SHIFT_W = 3
) (
   input  logic [DATA_W-1:0]  data,
   input  logic [SHIFT_W-1:0] shift,
   output logic [DATA_W-1:0]  result,
   output logic               sat
);

   // Wide enough that the largest shift cannot lose any bit before the overflow test
   localparam int unsigned WIDE_W = DATA_W + (2 ** SHIFT_W);

   logic [WIDE_W-1:0] wide;

   // Shift at full width, flag any bit that landed above the sample width
   always_comb begin
      wide   = WIDE_W'(data) << shift;
      sat    = |wide[WIDE_W-1:DATA_W];
      result = sat ? '1 : wide[DATA_W-1:0];
   end

endmodule

// File: rtl/volts_scale_pipe.sv
// Two-stage volts/div scaler: S1 applies saturating 2^shift gain, S2 applies clamp/deadband.
// Valid/ready stream with backpressure; counts clipped samples delivered downstream.
module volts_scale_pipe
   import volts_scale_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SHIFT_W = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_load,
   input  mode_t              cfg_mode,
   input  logic [DATA_W-1:0]  cfg_thresh,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_clip,
   output logic [CNT_W-1:0]   clip_count,
   input  logic               clip_clr
);

   // Active configuration
   mode_t              cfg_mode_q;
   logic [DATA_W-1:0]  cfg_thresh_q;
   logic [SHIFT_W-1:0] cfg_shift_q;

   // S1: gained sample plus the config it must be finished with
   logic               s1_valid_q;
   logic [DATA_W-1:0]  s1_gain_q;
   logic               s1_sat_q;
   mode_t              s1_mode_q;
   logic [DATA_W-1:0]  s1_thresh_q;

   // S2: final sample presented downstream
   logic               s2_valid_q;
   logic [DATA_W-1:0]  s2_data_q;
   logic               s2_clip_q;

   logic [CNT_W-1:0]   clip_count_q, clip_count_d;

   logic               adv1, adv2;
   logic [DATA_W-1:0]  gain;
   logic               sat;
   logic [DATA_W-1:0]  mode_data;
   logic               mode_clip;

   volts_sat_shl #(
      .DATA_W  (DATA_W),
      .SHIFT_W (SHIFT_W)
   ) u_sat_shl (
      .data   (in_data),
      .shift  (cfg_shift_q),
      .result (gain),
      .sat    (sat)
   );

   // Stage advance: a stage may load when it is empty or its content moves on this edge
   always_comb begin
      adv2     = !s2_valid_q || out_ready;
      adv1     = !s1_valid_q || adv2;
      in_ready = adv1;
   end

   // Mode stage: clamp ceiling or deadband floor against the sample's own threshold
   always_comb begin
      mode_data = s1_gain_q;
      mode_clip = s1_sat_q;
      unique case (s1_mode_q)
         CLAMP: begin
            if (s1_gain_q > s1_thresh_q) begin
               mode_data = s1_thresh_q;
               mode_clip = 1'b1;
            end
         end
         DEADBAND: begin
            if (s1_gain_q < s1_thresh_q) begin
               mode_data = '0;
            end
         end
         default: begin
            // PASS and RSVD forward the gained sample unchanged
         end
      endcase
   end

   // Clip counter next state: clear wins, otherwise saturating increment on a clipped handoff
   always_comb begin
      clip_count_d = clip_count_q;
      if (clip_clr) begin
         clip_count_d = '0;
      end else if (s2_valid_q && out_ready && s2_clip_q && !(&clip_count_q)) begin
         clip_count_d = clip_count_q + 1'b1;
      end
   end

   // Config register; a sample accepted on the load edge still sees the old values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_mode_q   <= RST_MODE;
         cfg_thresh_q <= DATA_W'(RST_THRESH);
         cfg_shift_q  <= SHIFT_W'(RST_SHIFT);
      end else if (cfg_load) begin
         cfg_mode_q   <= cfg_mode;
         cfg_thresh_q <= cfg_thresh;
         cfg_shift_q  <= cfg_shift;
      end
   end

   // S1 register: gain result and captured mode/threshold travel with the sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_gain_q   <= '0;
         s1_sat_q    <= 1'b0;
         s1_mode_q   <= RST_MODE;
         s1_thresh_q <= '0;
      end else if (adv1) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_gain_q   <= gain;
            s1_sat_q    <= sat;
            s1_mode_q   <= cfg_mode_q;
            s1_thresh_q <= cfg_thresh_q;
         end
      end
   end

   // S2 register: holds its payload while downstream stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_clip_q  <= 1'b0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= mode_data;
            s2_clip_q <= mode_clip;
         end
      end
   end

   // Clip counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clip_count_q <= '0;
      end else begin
         clip_count_q <= clip_count_d;
      end
   end

   // Outputs come straight from registers, so in_valid never reaches out_valid combinationally
   always_comb begin
      out_valid  = s2_valid_q;
      out_data   = s2_data_q;
      out_clip   = s2_clip_q;
      clip_count = clip_count_q;
   end

endmodule
